// File: rtl/idma_backend_channel_arb.sv
// idma_backend_channel_arb: round-robin arbiter that merges per-channel iDMA
// requests onto one backend and routes backend responses back in request order.
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   ch_req_valid_i/ch_req_ready_o      per-channel request handshake
//   ch_req_i                           per-channel payloads, channel c at [c*ReqWidth +: ReqWidth]
//   be_req_valid_o/be_req_ready_i/be_req_o  request toward backend
//   be_rsp_valid_i/be_rsp_ready_o/be_rsp_i  response from backend
//   ch_rsp_valid_o/ch_rsp_ready_i      per-channel response handshake
//   ch_rsp_o                           response payload, broadcast to all channels
//   ch_busy_o                          channel has outstanding requests
//   idle_o                             no outstanding requests at all
module idma_backend_channel_arb #(
    parameter int unsigned NumChannels    = 4,
    parameter int unsigned ReqWidth       = 128,
    parameter int unsigned RspWidth       = 40,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumChannels-1:0]          ch_req_valid_i,
    output logic [NumChannels-1:0]          ch_req_ready_o,
    input  logic [NumChannels*ReqWidth-1:0] ch_req_i,
    output logic                            be_req_valid_o,
    input  logic                            be_req_ready_i,
    output logic [ReqWidth-1:0]             be_req_o,
    input  logic                            be_rsp_valid_i,
    output logic                            be_rsp_ready_o,
    input  logic [RspWidth-1:0]             be_rsp_i,
    output logic [NumChannels-1:0]          ch_rsp_valid_o,
    input  logic [NumChannels-1:0]          ch_rsp_ready_i,
    output logic [RspWidth-1:0]             ch_rsp_o,
    output logic [NumChannels-1:0]          ch_busy_o,
    output logic                            idle_o
);
    localparam int unsigned ChIdxWidth = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned CntWidth   = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrWidth   = $clog2(MaxOutstanding);

    logic [ChIdxWidth-1:0] rr_q, lock_idx_q, rr_idx, grant, idx, head;
    logic                  locked_q, full, empty, req_hs, rsp_hs;
    logic [ChIdxWidth-1:0] id_mem [MaxOutstanding];
    logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]   fifo_cnt_q;
    logic [CntWidth-1:0]   ch_cnt_q [NumChannels];
    logic [NumChannels-1:0] ch_inc, ch_dec;

    // Scan downward so the last hit is the first valid channel at or after rr_q.
    always_comb begin
        rr_idx = rr_q;
        idx    = '0;
        for (int i = int'(NumChannels) - 1; i >= 0; i--) begin
            idx = ChIdxWidth'((int'(rr_q) + i) % int'(NumChannels));
            if (ch_req_valid_i[idx]) rr_idx = idx;
        end
    end

    // A stalled grant is held until its handshake so the backend sees a stable payload.
    assign grant          = (locked_q && ch_req_valid_i[lock_idx_q]) ? lock_idx_q : rr_idx;
    assign empty          = fifo_cnt_q == '0;
    assign full           = fifo_cnt_q == CntWidth'(MaxOutstanding);
    // Full is taken from registered count only, so a same-cycle pop never frees a push.
    assign be_req_valid_o = rst_ni & (|ch_req_valid_i) & ~full;
    assign be_req_o       = ch_req_i[grant*ReqWidth +: ReqWidth];
    assign req_hs         = be_req_valid_o & be_req_ready_i;
    assign ch_req_ready_o = req_hs ? NumChannels'(1) << grant : '0;

    assign head           = id_mem[rd_ptr_q];
    assign be_rsp_ready_o = ~empty & ch_rsp_ready_i[head];
    assign ch_rsp_valid_o = (be_rsp_valid_i & ~empty) ? NumChannels'(1) << head : '0;
    assign ch_rsp_o       = be_rsp_i;
    assign rsp_hs         = be_rsp_valid_i & be_rsp_ready_o;
    assign idle_o         = empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            locked_q   <= be_req_valid_o & ~be_req_ready_i;
            lock_idx_q <= grant;
            if (req_hs) begin
                rr_q     <= (grant == ChIdxWidth'(NumChannels - 1)) ? '0 : grant + ChIdxWidth'(1);
                wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            end
            if (rsp_hs) rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            fifo_cnt_q <= fifo_cnt_q + CntWidth'(req_hs) - CntWidth'(rsp_hs);
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_hs) id_mem[wr_ptr_q] <= grant;
    end

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        assign ch_inc[c]    = req_hs && grant == ChIdxWidth'(c);
        assign ch_dec[c]    = rsp_hs && head == ChIdxWidth'(c);
        assign ch_busy_o[c] = ch_cnt_q[c] != '0;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) ch_cnt_q[c] <= '0;
            else         ch_cnt_q[c] <= ch_cnt_q[c] + CntWidth'(ch_inc[c]) - CntWidth'(ch_dec[c]);
        end
        always @(posedge clk_i) begin
            if (rst_ni) begin
                assert (!(ch_inc[c] && !ch_dec[c] && ch_cnt_q[c] == CntWidth'(MaxOutstanding)))
                    else $error("channel %0d counter overflow", c);
                assert (!(ch_dec[c] && !ch_inc[c] && ch_cnt_q[c] == '0))
                    else $error("channel %0d counter underflow", c);
            end
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni) assert (!(req_hs && full)) else $error("id fifo push while full");
    end
endmodule

// File: tb/tb_idma_backend_channel_arb.sv
// tb_idma_backend_channel_arb: directed self-checking bench for the channel arbiter.
module tb_idma_backend_channel_arb;
    localparam int N  = 4;
    localparam int RW = 128;
    localparam int SW = 40;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    ch_req_valid = '0, ch_req_ready, ch_rsp_valid, ch_rsp_ready = '1, ch_busy;
    logic [N*RW-1:0] ch_req = '0;
    logic            be_req_valid, be_req_ready = 1'b0, be_rsp_valid = 1'b0, be_rsp_ready, idle;
    logic [RW-1:0]   be_req;
    logic [SW-1:0]   be_rsp = '0, ch_rsp;
    int              n_cmp = 0, n_err = 0;

    idma_backend_channel_arb dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ch_req_valid_i(ch_req_valid), .ch_req_ready_o(ch_req_ready), .ch_req_i(ch_req),
        .be_req_valid_o(be_req_valid), .be_req_ready_i(be_req_ready), .be_req_o(be_req),
        .be_rsp_valid_i(be_rsp_valid), .be_rsp_ready_o(be_rsp_ready), .be_rsp_i(be_rsp),
        .ch_rsp_valid_o(ch_rsp_valid), .ch_rsp_ready_i(ch_rsp_ready), .ch_rsp_o(ch_rsp),
        .ch_busy_o(ch_busy), .idle_o(idle)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] pay(input int c);
        return {32'hC0DE_0000 + 32'(c), 32'(c * 7 + 1), 32'hA5A5_A5A5 ^ 32'(c), 32'(c)};
    endfunction

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_be_req_valid"}, RW'(be_req_valid), RW'(0));
        chk({tag, "_ch_req_ready"}, RW'(ch_req_ready), RW'(0));
        chk({tag, "_be_rsp_ready"}, RW'(be_rsp_ready), RW'(0));
        chk({tag, "_ch_rsp_valid"}, RW'(ch_rsp_valid), RW'(0));
        chk({tag, "_busy"}, RW'(ch_busy), RW'(0));
        chk({tag, "_idle"}, RW'(idle), RW'(1));
    endtask

    initial begin
        int hs [3] = '{3, 0, 1};
        for (int c = 0; c < N; c++) ch_req[c*RW +: RW] = pay(c);
        // Reset with everything asserted: outputs must still be quiet.
        ch_req_valid = 4'hF; be_req_ready = 1'b1; be_rsp_valid = 1'b1;
        #3;
        chk_reset_outputs("rst");
        ch_req_valid = '0; be_req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        // Spurious backend response with nothing outstanding is not consumed.
        chk("spur_be_rsp_ready", RW'(be_rsp_ready), RW'(0));
        chk("spur_ch_rsp_valid", RW'(ch_rsp_valid), RW'(0));
        tick();
        chk("spur_idle", RW'(idle), RW'(1));
        be_rsp_valid = 1'b0;

        // Grant lock: ch2 stalled, ch0 raises valid, rr starts at 0.
        ch_req_valid = 4'b0100; be_req_ready = 1'b0; #1;
        chk("lock_valid0", RW'(be_req_valid), RW'(1));
        chk("lock_pay0", be_req, pay(2));
        chk("lock_rdy0", RW'(ch_req_ready), RW'(0));
        tick();
        ch_req_valid = 4'b0101; #1;
        chk("lock_pay1", be_req, pay(2));
        chk("lock_rdy1", RW'(ch_req_ready), RW'(0));
        tick(); #1;
        chk("lock_pay2", be_req, pay(2));
        tick();
        be_req_ready = 1'b1; #1;
        chk("lock_rdy3", RW'(ch_req_ready), RW'(4'b0100));
        chk("lock_pay3", be_req, pay(2));
        tick(); #1;
        chk("after_lock_rdy", RW'(ch_req_ready), RW'(4'b0001));
        chk("after_lock_pay", be_req, pay(0));
        tick();
        ch_req_valid = '0; be_req_ready = 1'b0; #1;
        chk("lock_busy", RW'(ch_busy), RW'(4'b0101));
        chk("lock_idle", RW'(idle), RW'(0));
        be_rsp_valid = 1'b1; be_rsp = 40'h11_2233_4455; #1;
        chk("drain_v0", RW'(ch_rsp_valid), RW'(4'b0100));
        chk("drain_data", RW'(ch_rsp), RW'(40'h11_2233_4455));
        tick(); #1;
        chk("drain_v1", RW'(ch_rsp_valid), RW'(4'b0001));
        tick();
        be_rsp_valid = 1'b0; #1;
        chk("drain_idle", RW'(idle), RW'(1));
        chk("drain_busy", RW'(ch_busy), RW'(0));

        // In-order response routing ch1, ch3, ch1 (rr now 1).
        be_req_ready = 1'b1; ch_req_valid = 4'b0010; #1;
        chk("ord_r0", RW'(ch_req_ready), RW'(4'b0010));
        tick();
        ch_req_valid = 4'b1000; #1;
        chk("ord_r1", RW'(ch_req_ready), RW'(4'b1000));
        tick();
        ch_req_valid = 4'b0010; #1;
        chk("ord_r2", RW'(ch_req_ready), RW'(4'b0010));
        tick();
        ch_req_valid = '0; be_req_ready = 1'b0; #1;
        chk("ord_busy0", RW'(ch_busy), RW'(4'b1010));
        be_rsp_valid = 1'b1; #1;
        chk("ord_v0", RW'(ch_rsp_valid), RW'(4'b0010));
        chk("ord_brdy0", RW'(be_rsp_ready), RW'(1));
        tick();
        ch_rsp_ready = 4'b0111; #1;
        chk("ord_v1", RW'(ch_rsp_valid), RW'(4'b1000));
        chk("ord_stall", RW'(be_rsp_ready), RW'(0));
        tick(); #1;
        chk("ord_v1_held", RW'(ch_rsp_valid), RW'(4'b1000));
        chk("ord_busy1", RW'(ch_busy), RW'(4'b1010));
        ch_rsp_ready = 4'hF; #1;
        chk("ord_brdy1", RW'(be_rsp_ready), RW'(1));
        tick(); #1;
        chk("ord_v2", RW'(ch_rsp_valid), RW'(4'b0010));
        chk("ord_busy2", RW'(ch_busy), RW'(4'b0010));
        tick();
        be_rsp_valid = 1'b0; #1;
        chk("ord_busy_end", RW'(ch_busy), RW'(0));
        chk("ord_idle_end", RW'(idle), RW'(1));

        // Fill the ID FIFO (rr now 2), then check pop does not free a same-cycle push.
        ch_req_valid = 4'hF; be_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] e;
            e = 4'(1 << ((2 + k) % 4));
            #1;
            chk($sformatf("fill_r%0d", k), RW'(ch_req_ready), RW'(e));
            tick();
        end
        #1;
        chk("full_valid", RW'(be_req_valid), RW'(0));
        chk("full_ready", RW'(ch_req_ready), RW'(0));
        chk("full_idle", RW'(idle), RW'(0));
        chk("full_busy", RW'(ch_busy), RW'(4'hF));
        be_rsp_valid = 1'b1; #1;
        chk("full_pop_brdy", RW'(be_rsp_ready), RW'(1));
        chk("full_pop_v", RW'(ch_rsp_valid), RW'(4'b0100));
        chk("full_pop_same_valid", RW'(be_req_valid), RW'(0));
        chk("full_pop_same_ready", RW'(ch_req_ready), RW'(0));
        tick();
        be_rsp_valid = 1'b0; #1;
        chk("full_next_valid", RW'(be_req_valid), RW'(1));
        chk("full_next_ready", RW'(ch_req_ready), RW'(4'b0100));
        tick();
        ch_req_valid = '0; be_req_ready = 1'b0; be_rsp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] e;
            e = 4'(1 << hs[k]);
            #1;
            chk($sformatf("pop_v%0d", k), RW'(ch_rsp_valid), RW'(e));
            tick();
        end
        be_rsp_valid = 1'b0; #1;
        chk("five_busy", RW'(ch_busy), RW'(4'hF));
        chk("five_idle", RW'(idle), RW'(0));

        // Reset mid-operation with 5 outstanding.
        ch_req_valid = 4'hF; be_req_ready = 1'b1; be_rsp_valid = 1'b1;
        rst_n = 1'b0; #1;
        chk_reset_outputs("midrst");
        be_rsp_valid = 1'b0;
        rst_n = 1'b1;
        // Post-reset round-robin from channel 0: 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            logic [3:0] e;
            e = 4'(1 << (k % 4));
            #1;
            chk($sformatf("rr_r%0d", k), RW'(ch_req_ready), RW'(e));
            chk($sformatf("rr_pay%0d", k), be_req, pay(k % 4));
            tick();
        end
        ch_req_valid = '0; be_req_ready = 1'b0; #1;
        chk("rr_busy", RW'(ch_busy), RW'(4'hF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/idma_backend_channel_arb.md
IDMA_BACKEND_CHANNEL_ARB -- requirements
Module: idma_backend_channel_arb

Interface
REQ-001 SHALL have parameter NumChannels, default 4, number of requesting channels (2..16).
REQ-002 SHALL have parameter ReqWidth, default 128, flattened 1D request payload width in bits.
REQ-003 SHALL have parameter RspWidth, default 40, flattened response payload width in bits.
REQ-004 SHALL have parameter MaxOutstanding, default 8, max accepted-but-unanswered requests (power of two, >=2).
REQ-005 SHALL derive localparams ChIdxWidth = max(1,$clog2(NumChannels)) and CntWidth = $clog2(MaxOutstanding+1); these are not overridable.
REQ-006 SHALL have port clk_i, input, 1, single clock, all state rising-edge.
REQ-007 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port ch_req_valid_i, input, NumChannels, per-channel request valid.
REQ-009 SHALL have port ch_req_ready_o, output, NumChannels, per-channel request ready.
REQ-010 SHALL have port ch_req_i, input, NumChannels*ReqWidth, per-channel payloads, channel c at bits [c*ReqWidth +: ReqWidth].
REQ-011 SHALL have port be_req_valid_o / be_req_ready_i / be_req_o, output / input / output, 1/1/ReqWidth, request toward backend.
REQ-012 SHALL have port be_rsp_valid_i / be_rsp_ready_o / be_rsp_i, input / output / input, 1/1/RspWidth, response from backend.
REQ-013 SHALL have port ch_rsp_valid_o / ch_rsp_ready_i, output / input, NumChannels each, per-channel response handshake.
REQ-014 SHALL have port ch_rsp_o, output, RspWidth, response payload broadcast to all channels.
REQ-015 SHALL have port ch_busy_o, output, NumChannels, channel has outstanding requests.
REQ-016 SHALL have port idle_o, output, 1, no outstanding requests at all.

Function
REQ-017 SHALL arbitrate round-robin: grant the first valid channel at or after priority pointer rr_q, wrapping NumChannels-1 -> 0.
REQ-018 SHALL forward granted payload combinationally: be_req_valid_o = any eligible valid, zero-cycle latency.
REQ-019 SHALL lock the grant while be_req_valid_o=1 and be_req_ready_i=0; payload and grant stay stable until handshake, even if higher-priority channels assert valid.
REQ-020 SHALL assert ch_req_ready_o[c] only for the granted channel, equal to be_req_ready_i and not full.
REQ-021 SHALL on request handshake set rr_q to granted index+1 (mod NumChannels) and push granted index into an in-order ID FIFO of depth MaxOutstanding.
REQ-022 SHALL when the ID FIFO is full hold be_req_valid_o=0 and all ch_req_ready_o=0; a pop in the same cycle SHALL NOT enable a push that cycle (no ready-to-ready combinational path).
REQ-023 SHALL route responses by FIFO head h: ch_rsp_valid_o[h]=be_rsp_valid_i, others 0; be_rsp_ready_o=ch_rsp_ready_i[h]; pop on handshake.
REQ-024 SHALL when FIFO empty hold be_rsp_ready_o=0 and all ch_rsp_valid_o=0 (spurious backend response not consumed).
REQ-025 SHALL keep per-channel counters (CntWidth): +1 on request handshake, -1 on response handshake, unchanged on simultaneous +1/-1 for the same channel.
REQ-026 SHALL drive ch_busy_o[c] = counter[c]!=0, idle_o = FIFO empty; both registered-state derived, no input combinational path.
REQ-027 SHALL assert (simulation only) no counter overflow/underflow and no push when full.

Reset
REQ-028 SHALL on rst_ni=0 asynchronously clear rr_q to 0, FIFO pointers/count to empty, all counters to 0; outputs: be_req_valid_o=0, ch_req_ready_o=0, be_rsp_ready_o=0, ch_rsp_valid_o=0, ch_busy_o=0, idle_o=1.
REQ-029 SHALL discard in-flight state on reset mid-operation; first cycle after deassertion grants channel 0 if valid.

Verification
REQ-030 All 4 channels valid, be_req_ready_i=1 constantly -> grants 0,1,2,3,0 on consecutive cycles.
REQ-031 Ch2 valid, be_req_ready_i=0 for 3 cycles, ch0 raises valid cycle 1 -> grant stays ch2, payload stable, ch0 granted after ch2 handshake.
REQ-032 MaxOutstanding=8, 8 requests accepted, no responses -> be_req_valid_o=0, all ch_req_ready_o=0, idle_o=0; one response popped -> push allowed next cycle, not same cycle.
REQ-033 Requests from ch1,ch3,ch1 then 3 responses -> delivered to ch1,ch3,ch1 in order; ch_rsp_ready_i[3]=0 stalls be_rsp_ready_o; ch_busy_o ends 0000, idle_o=1.
REQ-034 be_rsp_valid_i=1 after reset with FIFO empty -> be_rsp_ready_o=0, no ch_rsp_valid_o.
REQ-035 Reset asserted with 5 outstanding -> all outputs at REQ-028 values immediately, counters 0.
